// File: rtl/date_display_ctrl.sv
// Board display controller: debounced keys select one of N_DATES BCD dates on six
// active-low 7-segment digits, with LED invert mode and timed auto-scroll.
module date_display_ctrl #(
    parameter int                    N_DATES         = 3,
    parameter logic [N_DATES*24-1:0] DATES           = {24'h250904, 24'h031208, 24'h010823},
    parameter int                    DEBOUNCE_CYCLES = 500000,
    parameter int                    SCROLL_CYCLES   = 50000000,
    localparam int                   IDX_W           = (N_DATES > 1) ? $clog2(N_DATES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       switch,
    input  logic [1:0]       key,
    output logic [9:0]       leds,
    output logic [7:0]       hex0,
    output logic [7:0]       hex1,
    output logic [7:0]       hex2,
    output logic [7:0]       hex3,
    output logic [7:0]       hex4,
    output logic [7:0]       hex5,
    output logic [IDX_W-1:0] date_idx
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SC_W = $clog2(SCROLL_CYCLES);

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] r;
        if (i >= IDX_W'(N_DATES - 1)) begin
            r = {IDX_W{1'b0}};
        end else begin
            r = i + IDX_W'(1);
        end
        return r;
    endfunction

    logic [1:0]       sync1_r, sync2_r, stable_r, armed_r;
    logic [DB_W-1:0]  db_cnt_r [2];
    logic [1:0]       fill_r;
    logic             invert_r;
    logic [SC_W-1:0]  timer_r;
    logic [IDX_W-1:0] date_idx_r;
    logic [9:0]       leds_r;
    logic [7:0]       hex_r [6];
    logic [1:0]       take_s, press_s;
    logic             terminal_s;
    logic [23:0]      cur_date_s;
    logic             unused_sw8_s;

    assign unused_sw8_s = switch[8];

    // Debounce acceptance and press detection; a key must be seen released after reset to arm.
    always_comb begin
        take_s  = 2'b00;
        press_s = 2'b00;
        for (int k = 0; k < 2; k++) begin
            take_s[k]  = (sync2_r[k] != stable_r[k]) && (db_cnt_r[k] == DB_W'(DEBOUNCE_CYCLES - 1));
            press_s[k] = take_s[k] && stable_r[k] && armed_r[k];
        end
    end

    // Key synchronisers, debounce counters and arming.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r  <= 2'b11;
            sync2_r  <= 2'b11;
            stable_r <= 2'b11;
            armed_r  <= 2'b00;
            fill_r   <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                db_cnt_r[k] <= {DB_W{1'b0}};
            end
        end else begin
            sync1_r <= key;
            sync2_r <= sync1_r;
            if (fill_r != 2'd2) begin
                fill_r <= fill_r + 2'd1;
            end
            for (int k = 0; k < 2; k++) begin
                if (take_s[k]) begin
                    stable_r[k] <= sync2_r[k];
                    db_cnt_r[k] <= {DB_W{1'b0}};
                end else if (sync2_r[k] != stable_r[k]) begin
                    db_cnt_r[k] <= db_cnt_r[k] + DB_W'(1);
                end else begin
                    db_cnt_r[k] <= {DB_W{1'b0}};
                end
                // fill_r guards against the reset value of the synchroniser posing as a release
                if (fill_r == 2'd2 && sync2_r[k]) begin
                    armed_r[k] <= 1'b1;
                end
            end
        end
    end

    assign terminal_s = switch[9] && (timer_r == SC_W'(SCROLL_CYCLES - 1));

    // Invert toggle, scroll timer and date index; a manual press always restarts the period.
    always_ff @(posedge clk) begin
        if (reset) begin
            invert_r   <= 1'b0;
            timer_r    <= {SC_W{1'b0}};
            date_idx_r <= {IDX_W{1'b0}};
        end else begin
            if (press_s[0]) begin
                invert_r <= ~invert_r;
            end
            if (press_s[1]) begin
                date_idx_r <= wrap_inc(date_idx_r);
                timer_r    <= {SC_W{1'b0}};
            end else if (!switch[9]) begin
                timer_r <= {SC_W{1'b0}};
            end else if (terminal_s) begin
                date_idx_r <= wrap_inc(date_idx_r);
                timer_r    <= {SC_W{1'b0}};
            end else begin
                timer_r <= timer_r + SC_W'(1);
            end
        end
    end

    // Select the current date word, blanking any unreachable index.
    always_comb begin
        cur_date_s = 24'hFFFFFF;
        if (int'(date_idx_r) < N_DATES) begin
            cur_date_s = DATES[24*int'(date_idx_r) +: 24];
        end else begin
            cur_date_s = 24'hFFFFFF;
        end
    end

    // Registered LED and 7-segment outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            leds_r <= 10'h000;
            for (int j = 0; j < 6; j++) begin
                hex_r[j] <= 8'hFF;
            end
        end else begin
            leds_r <= {switch[9], invert_r, (invert_r ? ~switch[7:0] : switch[7:0])};
            for (int j = 0; j < 6; j++) begin
                hex_r[j] <= seg7(cur_date_s[4*j +: 4]);
            end
        end
    end

    assign leds     = leds_r;
    assign date_idx = date_idx_r;
    assign hex0     = hex_r[0];
    assign hex1     = hex_r[1];
    assign hex2     = hex_r[2];
    assign hex3     = hex_r[3];
    assign hex4     = hex_r[4];
    assign hex5     = hex_r[5];

endmodule

// File: tb/tb_date_display_ctrl.sv
// Directed bench for date_display_ctrl: LED vector table plus hand-written key/scroll/reset sequences.
module tb_date_display_ctrl;

    logic       clk;
    logic       reset;
    logic [9:0] switch;
    logic [1:0] key;
    logic [9:0] leds;
    logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [1:0] date_idx;

    int checks   = 0;
    int failures = 0;

    date_display_ctrl #(
        .N_DATES(3),
        .DATES({24'h250904, 24'h031208, 24'h010823}),
        .DEBOUNCE_CYCLES(4),
        .SCROLL_CYCLES(10)
    ) dut (
        .clk(clk), .reset(reset), .switch(switch), .key(key), .leds(leds),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .date_idx(date_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sw;
        logic       press;
        logic [9:0] exp_leds;
    } led_vec_t;

    led_vec_t vec [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press_key(input int k);
        key[k] = 1'b0;
        repeat (10) tick();
        key[k] = 1'b1;
        repeat (10) tick();
    endtask

    // Counts edges until date_idx moves; 0 means it never moved within the bound.
    task automatic wait_change(output int n);
        logic [1:0] start;
        logic       done;
        start = date_idx;
        done  = 1'b0;
        n     = 0;
        for (int i = 1; i <= 40; i++) begin
            if (!done) begin
                tick();
                if (date_idx !== start) begin
                    n    = i;
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vec[0] = '{10'h0A5, 1'b0, 10'h0A5};
        vec[1] = '{10'h0A5, 1'b1, 10'h15A};
        vec[2] = '{10'h0A5, 1'b1, 10'h0A5};
        vec[3] = '{10'h0FF, 1'b1, 10'h100};
        vec[4] = '{10'h0A5, 1'b0, 10'h15A};
        vec[5] = '{10'h000, 1'b0, 10'h1FF};
        vec[6] = '{10'h13C, 1'b0, 10'h1C3};
        vec[7] = '{10'h13C, 1'b1, 10'h03C};

        // reset state and first hex image
        reset  = 1'b1;
        key    = 2'b11;
        switch = 10'h000;
        repeat (3) tick();
        check("rst_leds", leds, 10'h000);
        check("rst_hex0", hex0, 8'hFF);
        check("rst_hex5", hex5, 8'hFF);
        check("rst_idx", date_idx, 2'd0);
        reset = 1'b0;
        tick();
        check("d0_hex5", hex5, 8'hC0);
        check("d0_hex4", hex4, 8'hF9);
        check("d0_hex3", hex3, 8'hC0);
        check("d0_hex2", hex2, 8'h80);
        check("d0_hex1", hex1, 8'hA4);
        check("d0_hex0", hex0, 8'hB0);

        // short glitch rejected, long hold gives one advance
        key[1] = 1'b0;
        repeat (3) tick();
        key[1] = 1'b1;
        repeat (10) tick();
        check("glitch_idx", date_idx, 2'd0);
        key[1] = 1'b0;
        wait_change(n);
        check("press_latency", n, 6);
        repeat (14) tick();
        check("hold_idx", date_idx, 2'd1);
        key[1] = 1'b1;
        repeat (10) tick();
        check("release_idx", date_idx, 2'd1);
        check("d1_hex0", hex0, 8'h80);

        // three presses with wrap
        press_key(1);
        check("p1_idx", date_idx, 2'd2);
        check("d2_hex5", hex5, 8'hA4);
        check("d2_hex4", hex4, 8'h92);
        check("d2_hex3", hex3, 8'hC0);
        check("d2_hex2", hex2, 8'h90);
        check("d2_hex1", hex1, 8'hC0);
        check("d2_hex0", hex0, 8'h99);
        press_key(1);
        check("p2_idx", date_idx, 2'd0);
        check("p2_hex0", hex0, 8'hB0);
        press_key(1);
        check("p3_idx", date_idx, 2'd1);
        check("p3_hex0", hex0, 8'h80);

        // LED invert table: switch changes one edge before each compare
        for (int i = 0; i < 8; i++) begin
            if (vec[i].press) begin
                press_key(0);
            end
            switch = vec[i].sw;
            tick();
            check($sformatf("leds_vec%0d", i), leds, vec[i].exp_leds);
        end

        // auto-scroll period, then a press landing on terminal count
        switch = 10'h200;
        wait_change(n);
        check("scroll1_cycles", n, 10);
        check("scroll1_idx", date_idx, 2'd2);
        check("scroll_led9", leds, 10'h200);
        wait_change(n);
        check("scroll2_cycles", n, 10);
        check("scroll2_idx", date_idx, 2'd0);
        repeat (4) tick();
        key[1] = 1'b0;
        wait_change(n);
        check("coinc_cycles", n, 6);
        check("coinc_idx", date_idx, 2'd1);
        wait_change(n);
        check("after_coinc_cycles", n, 10);
        check("after_coinc_idx", date_idx, 2'd2);
        key[1] = 1'b1;
        switch = 10'h000;
        repeat (15) tick();
        check("scroll_off_idx", date_idx, 2'd2);

        // reset mid-scroll with key held; held key must not register afterwards
        switch = 10'h200;
        repeat (5) tick();
        key[1] = 1'b0;
        repeat (2) tick();
        reset  = 1'b1;
        switch = 10'h000;
        repeat (3) tick();
        check("rst2_leds", leds, 10'h000);
        check("rst2_hex0", hex0, 8'hFF);
        check("rst2_idx", date_idx, 2'd0);
        reset = 1'b0;
        repeat (20) tick();
        check("held_after_rst_idx", date_idx, 2'd0);
        check("held_after_rst_hex0", hex0, 8'hB0);
        key[1] = 1'b1;
        repeat (10) tick();
        check("release_after_rst_idx", date_idx, 2'd0);
        press_key(1);
        check("repress_idx", date_idx, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
